// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: key-event FSM state codes and default hold durations.
// Durations are counted in 1 kHz clock cycles, so 1 cycle = 1 ms.
package stopwatch_pkg;

  localparam logic [1:0] ST_ARM     = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_PRESSED = 2'd2;
  localparam logic [1:0] ST_LONG    = 2'd3;

  localparam int LONG_MS_DEF   = 1000;
  localparam int REPEAT_MS_DEF = 200;

endpackage

// File: rtl/key_event.sv
// Turns a debounced key level into single-cycle press/click/long/repeat/release pulses plus a held level.
// All outputs are registered, 1 cycle after the sampling edge; no backpressure, pulses are fire-and-forget.
module key_event
  import stopwatch_pkg::*;
#(
  parameter int LONG_MS   = LONG_MS_DEF,
  parameter int REPEAT_MS = REPEAT_MS_DEF,
  parameter int CNT_W     = 11
) (
  input  logic clk_1khz,
  input  logic rst_n,
  input  logic key_in,
  input  logic repeat_en,
  output logic press_pulse,
  output logic click_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic release_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_TH   = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] REPEAT_TH = CNT_W'(REPEAT_MS - 1);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_nxt, click_nxt, long_nxt, repeat_nxt, release_nxt, held_nxt;

  // Release is tested before any threshold so a coincident release suppresses long/repeat.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    click_nxt   = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    release_nxt = 1'b0;
    case (state)
      ST_ARM: begin
        cnt_nxt = '0;
        if (!key_in) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        cnt_nxt = '0;
        if (key_in) begin
          state_nxt = ST_PRESSED;
          press_nxt = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!key_in) begin
          state_nxt   = ST_IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
          click_nxt   = 1'b1;
        end else if (cnt == LONG_TH) begin
          state_nxt = ST_LONG;
          cnt_nxt   = '0;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_LONG: begin
        if (!key_in) begin
          state_nxt   = ST_IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else if (!repeat_en) begin
          // Parked at 0 so re-enabling starts a full repeat period.
          cnt_nxt = '0;
        end else if (cnt == REPEAT_TH) begin
          cnt_nxt    = '0;
          repeat_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_ARM;
        cnt_nxt   = '0;
      end
    endcase
    held_nxt = (state_nxt == ST_PRESSED) || (state_nxt == ST_LONG);
  end

  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_ARM;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      press_pulse   <= press_nxt;
      click_pulse   <= click_nxt;
      long_pulse    <= long_nxt;
      repeat_pulse  <= repeat_nxt;
      release_pulse <= release_nxt;
      held          <= held_nxt;
    end
  end

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event with LONG_MS=10, REPEAT_MS=4.
// Output vector order: {press, click, long, repeat, release, held}.
module tb_key_event;

  logic clk_1khz = 1'b0;
  logic rst_n;
  logic key_in;
  logic repeat_en;
  logic press_pulse, click_pulse, long_pulse, repeat_pulse, release_pulse, held;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [5:0] NONE      = 6'b000000;
  localparam logic [5:0] HELD      = 6'b000001;
  localparam logic [5:0] PRESS     = 6'b100001;
  localparam logic [5:0] CLICK_REL = 6'b010010;
  localparam logic [5:0] LONG      = 6'b001001;
  localparam logic [5:0] RPT       = 6'b000101;
  localparam logic [5:0] REL       = 6'b000010;

  key_event #(.LONG_MS(10), .REPEAT_MS(4), .CNT_W(11)) dut (
    .clk_1khz      (clk_1khz),
    .rst_n         (rst_n),
    .key_in        (key_in),
    .repeat_en     (repeat_en),
    .press_pulse   (press_pulse),
    .click_pulse   (click_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .release_pulse (release_pulse),
    .held          (held)
  );

  always #5 clk_1khz = ~clk_1khz;

  task automatic tick();
    @(posedge clk_1khz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {press_pulse, click_pulse, long_pulse, repeat_pulse, release_pulse, held};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected outputs i cycles after press_pulse while the key stays down.
  function automatic logic [5:0] exp_hold(input int i, input bit rpt_on, input int rpt_first);
    if (i == 10) return LONG;
    if (rpt_on && i >= rpt_first && ((i - rpt_first) % 4) == 0) return RPT;
    return HELD;
  endfunction

  initial begin
    rst_n     = 1'b0;
    key_in    = 1'b1;
    repeat_en = 1'b1;
    #2;
    chk("reset_async", NONE);
    tick(); chk("reset_clk0", NONE);
    tick(); chk("reset_clk1", NONE);
    rst_n = 1'b1;

    // Key already down at reset: ARM must stay silent.
    for (int i = 0; i < 5; i++) begin
      tick(); chk($sformatf("arm_hold_%0d", i), NONE);
    end
    key_in = 1'b0;
    tick(); chk("arm_release", NONE);
    tick(); chk("idle_wait", NONE);
    // Minimum press: one sampled-high cycle.
    key_in = 1'b1;
    tick(); chk("second_press", PRESS);
    key_in = 1'b0;
    tick(); chk("min_press_click", CLICK_REL);
    tick(); chk("min_press_after", NONE);

    // Short press, 3 cycles.
    key_in = 1'b1;
    tick(); chk("short_P", PRESS);
    tick(); chk("short_P1", HELD);
    tick(); chk("short_P2", HELD);
    key_in = 1'b0;
    tick(); chk("short_P3_click", CLICK_REL);
    tick(); chk("short_after", NONE);

    // Long hold 20 cycles, repeat enabled.
    repeat_en = 1'b1;
    key_in = 1'b1;
    tick(); chk("rep_P", PRESS);
    for (int i = 1; i < 20; i++) begin
      tick(); chk($sformatf("rep_P%0d", i), exp_hold(i, 1'b1, 14));
    end
    key_in = 1'b0;
    tick(); chk("rep_release", REL);
    tick(); chk("rep_after", NONE);

    // Long hold 20 cycles, repeat disabled.
    repeat_en = 1'b0;
    key_in = 1'b1;
    tick(); chk("norep_P", PRESS);
    for (int i = 1; i < 20; i++) begin
      tick(); chk($sformatf("norep_P%0d", i), exp_hold(i, 1'b0, 14));
    end
    key_in = 1'b0;
    tick(); chk("norep_release", REL);
    tick(); chk("norep_after", NONE);

    // Enabling repeat mid-LONG restarts the period from the first enabled sample.
    key_in = 1'b1;
    tick(); chk("late_P", PRESS);
    for (int i = 1; i <= 12; i++) begin
      tick(); chk($sformatf("late_P%0d", i), exp_hold(i, 1'b0, 14));
    end
    repeat_en = 1'b1;
    for (int i = 13; i <= 21; i++) begin
      tick(); chk($sformatf("late_P%0d", i), exp_hold(i, 1'b1, 16));
    end
    key_in = 1'b0;
    tick(); chk("late_release", REL);

    // Release sampled on the cycle the counter would hit LONG_MS-1.
    key_in = 1'b1;
    tick(); chk("race_P", PRESS);
    for (int i = 1; i <= 9; i++) begin
      tick(); chk($sformatf("race_P%0d", i), HELD);
    end
    key_in = 1'b0;
    tick(); chk("race_P10_click", CLICK_REL);
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("race_after_%0d", i), NONE);
    end

    // Reset while in LONG, key kept down through and after reset.
    key_in = 1'b1;
    tick(); chk("rst_P", PRESS);
    for (int i = 1; i <= 11; i++) begin
      tick(); chk($sformatf("rst_P%0d", i), exp_hold(i, 1'b1, 14));
    end
    rst_n = 1'b0;
    #1;
    chk("rst_immediate", NONE);
    tick(); chk("rst_low_clk", NONE);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("rst_arm_%0d", i), NONE);
    end
    key_in = 1'b0;
    tick(); chk("rst_arm_release", NONE);
    key_in = 1'b1;
    tick(); chk("rst_repress", PRESS);
    key_in = 1'b0;
    tick(); chk("rst_repress_click", CLICK_REL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
